// File: rtl/ftdi_tx_sched_pkg.sv
// Shared definitions for the FTDI transmit scheduler: state encoding, frame
// constants and the payload length width.
package ftdi_tx_sched_pkg;

  localparam int LEN_W = 11;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] RSP_TAG  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TAG,
    ST_LEN_H,
    ST_LEN_L,
    ST_PAYLOAD,
    ST_ACK
  } state_t;

  typedef enum logic {
    SRC_MON = 1'b0,
    SRC_RSP = 1'b1
  } src_t;

endpackage

// File: rtl/ftdi_tx_sched_if.sv
// Bundle of the two frame-source handshakes and the FT245 write port.
// The master side is the scheduler, the slave side is its environment.
interface ftdi_tx_sched_if;
  import ftdi_tx_sched_pkg::*;

  logic             mon_rd_rdy;
  logic             mon_rd_rdy_ack;
  logic             mon_src;
  logic [LEN_W-1:0] mon_usedw;
  logic             mon_rdreq;
  logic [7:0]       mon_q;
  logic             rsp_rdy;
  logic [LEN_W-1:0] rsp_len;
  logic             rsp_rd_rdy_ack;
  logic             rsp_rdreq;
  logic [7:0]       rsp_q;
  logic             ftdi_txe_n;
  logic             ftdi_wr_n;
  logic [7:0]       ftdi_d;
  logic             busy;

  modport master (
    input  mon_rd_rdy, mon_src, mon_usedw, mon_q,
    input  rsp_rdy, rsp_len, rsp_q, ftdi_txe_n,
    output mon_rd_rdy_ack, mon_rdreq, rsp_rd_rdy_ack, rsp_rdreq,
    output ftdi_wr_n, ftdi_d, busy
  );

  modport slave (
    output mon_rd_rdy, mon_src, mon_usedw, mon_q,
    output rsp_rdy, rsp_len, rsp_q, ftdi_txe_n,
    input  mon_rd_rdy_ack, mon_rdreq, rsp_rd_rdy_ack, rsp_rdreq,
    input  ftdi_wr_n, ftdi_d, busy
  );

endinterface

// File: rtl/ftdi_out_reg.sv
// One-byte output holding register for the FT245 write port; a byte leaves
// on any edge where it is valid and the chip reports space.
module ftdi_out_reg (
  input  logic       clk_ftdi,
  input  logic       n_rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       txe_n,
  output logic [7:0] ob,
  output logic       ob_vld,
  output logic       accept,
  output logic       wr_n
);

  assign accept = ob_vld & ~txe_n;
  assign wr_n   = ~accept;

  // A reload on the accepting edge keeps the register full for the next byte.
  always_ff @(posedge clk_ftdi or negedge n_rst) begin
    if (!n_rst) begin
      ob     <= 8'h00;
      ob_vld <= 1'b0;
    end else if (load) begin
      ob     <= din;
      ob_vld <= 1'b1;
    end else if (accept) begin
      ob_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ftdi_tx_sched.sv
// Round-robin transmit scheduler sharing the FT245 write port between the
// HSI monitor buffer and the command-response buffer.
module ftdi_tx_sched
  import ftdi_tx_sched_pkg::*;
(
  input logic            clk_ftdi,
  input logic            n_rst,
  ftdi_tx_sched_if.master bus
);

  state_t           state;
  src_t             src;
  src_t             last;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] rem;
  logic [7:0]       tag;
  logic             rd_pend;
  logic             mon_ack;
  logic             rsp_ack;

  logic             grant_any;
  src_t             grant_src;
  logic [LEN_W-1:0] grant_len;
  logic             load;
  logic [7:0]       din;
  logic [7:0]       ob;
  logic             ob_vld;
  logic             accept;
  logic             rd_issue;
  logic [7:0]       q;

  always_comb begin
    grant_any = bus.mon_rd_rdy | bus.rsp_rdy;
    grant_src = (bus.mon_rd_rdy && (!bus.rsp_rdy || last == SRC_RSP)) ? SRC_MON : SRC_RSP;
    grant_len = (grant_src == SRC_MON) ? bus.mon_usedw : bus.rsp_len;
  end

  assign q = (src == SRC_MON) ? bus.mon_q : bus.rsp_q;

  // Only one read in flight, and only when the fetched byte has room to land.
  assign rd_issue = (state == ST_PAYLOAD) && (rem != '0) && !rd_pend && (!ob_vld || accept);

  always_comb begin
    load = 1'b0;
    din  = 8'h00;
    case (state)
      ST_IDLE:    begin load = grant_any; din = HDR_BYTE;          end
      ST_HDR:     begin load = accept;    din = tag;               end
      ST_TAG:     begin load = accept;    din = {5'b0, len[10:8]}; end
      ST_LEN_H:   begin load = accept;    din = len[7:0];          end
      ST_PAYLOAD: begin load = rd_pend;   din = q;                 end
      default:    ;
    endcase
  end

  ftdi_out_reg u_out_reg (
    .clk_ftdi (clk_ftdi),
    .n_rst    (n_rst),
    .load     (load),
    .din      (din),
    .txe_n    (bus.ftdi_txe_n),
    .ob       (ob),
    .ob_vld   (ob_vld),
    .accept   (accept),
    .wr_n     (bus.ftdi_wr_n)
  );

  always_ff @(posedge clk_ftdi or negedge n_rst) begin
    if (!n_rst) begin
      state   <= ST_IDLE;
      src     <= SRC_MON;
      last    <= SRC_RSP;
      len     <= '0;
      rem     <= '0;
      tag     <= 8'h00;
      rd_pend <= 1'b0;
      mon_ack <= 1'b0;
      rsp_ack <= 1'b0;
    end else begin
      mon_ack <= 1'b0;
      rsp_ack <= 1'b0;
      rd_pend <= rd_issue;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            src   <= grant_src;
            len   <= grant_len;
            rem   <= grant_len;
            tag   <= (grant_src == SRC_RSP) ? RSP_TAG : {7'b0, bus.mon_src};
            state <= ST_HDR;
          end
        end
        ST_HDR:   if (accept) state <= ST_TAG;
        ST_TAG:   if (accept) state <= ST_LEN_H;
        ST_LEN_H: if (accept) state <= ST_LEN_L;
        ST_LEN_L: begin
          if (accept) begin
            if (len == '0) begin
              state   <= ST_ACK;
              mon_ack <= (src == SRC_MON);
              rsp_ack <= (src == SRC_RSP);
            end else begin
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rd_pend) begin
            rem <= rem - LEN_W'(1);
          end else if (rem == '0 && accept) begin
            state   <= ST_ACK;
            mon_ack <= (src == SRC_MON);
            rsp_ack <= (src == SRC_RSP);
          end
        end
        ST_ACK: begin
          last  <= src;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mon_rdreq      = rd_issue && (src == SRC_MON);
  assign bus.rsp_rdreq      = rd_issue && (src == SRC_RSP);
  assign bus.mon_rd_rdy_ack = mon_ack;
  assign bus.rsp_rd_rdy_ack = rsp_ack;
  assign bus.ftdi_d         = ob;
  assign bus.busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_ftdi_tx_sched.sv
// Bench for ftdi_tx_sched: models both frame FIFOs and the FTDI host, and
// predicts the host byte stream from the round-robin framing rules.
module tb_ftdi_tx_sched;

  logic clk_ftdi = 1'b0;
  logic n_rst;
  always #5 clk_ftdi = ~clk_ftdi;

  ftdi_tx_sched_if bus ();

  ftdi_tx_sched dut (
    .clk_ftdi (clk_ftdi),
    .n_rst    (n_rst),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc, last_acc_cyc, prev_ack_cyc;
  int excl_err, timing_err, underflow, mon_rd_cnt, rsp_rd_cnt;
  bit bp, mon_pend, rsp_pend, model_last_rsp;
  byte unsigned mon_fifo[$], rsp_fifo[$], host[$], exp_bytes[$], mon_data[$], rsp_data[$];
  int acc_cyc[$], ack_log[$], exp_ack[$];
  int mon_len_q[$], rsp_len_q[$], mon_lens[$], rsp_lens[$];
  bit mon_src_q[$], mon_srcs[$];

  task automatic clear_env();
    mon_fifo.delete(); rsp_fifo.delete(); host.delete(); exp_bytes.delete();
    mon_data.delete(); rsp_data.delete(); acc_cyc.delete(); ack_log.delete();
    exp_ack.delete(); mon_len_q.delete(); rsp_len_q.delete(); mon_lens.delete();
    rsp_lens.delete(); mon_src_q.delete(); mon_srcs.delete();
    cyc = 0; last_acc_cyc = -10; prev_ack_cyc = -10;
    excl_err = 0; timing_err = 0; underflow = 0; mon_rd_cnt = 0; rsp_rd_cnt = 0;
    bp = 1'b0; mon_pend = 1'b0; rsp_pend = 1'b0;
    bus.mon_rd_rdy = 1'b0; bus.rsp_rdy = 1'b0; bus.mon_usedw = '0; bus.rsp_len = '0;
    bus.mon_src = 1'b0; bus.mon_q = 8'h00; bus.rsp_q = 8'h00; bus.ftdi_txe_n = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk_ftdi);
    n_rst = 1'b1;
    model_last_rsp = 1'b1;
  endtask

  task automatic add_mon(int len, bit src, bit fixed);
    mon_len_q.push_back(len); mon_lens.push_back(len);
    mon_src_q.push_back(src); mon_srcs.push_back(src);
    for (int i = 0; i < len; i++) begin
      byte unsigned b;
      b = fixed ? 8'(17 * (i + 1)) : 8'($urandom);
      mon_fifo.push_back(b); mon_data.push_back(b);
    end
  endtask

  task automatic add_rsp(int len);
    rsp_len_q.push_back(len); rsp_lens.push_back(len);
    for (int i = 0; i < len; i++) begin
      byte unsigned b;
      b = 8'($urandom);
      rsp_fifo.push_back(b); rsp_data.push_back(b);
    end
  endtask

  task automatic raise_mon();
    if (mon_len_q.size() > 0) begin
      bus.mon_usedw = 11'(mon_len_q.pop_front());
      bus.mon_src = mon_src_q.pop_front();
      bus.mon_rd_rdy = 1'b1;
    end
  endtask

  task automatic raise_rsp();
    if (rsp_len_q.size() > 0) begin
      bus.rsp_len = 11'(rsp_len_q.pop_front());
      bus.rsp_rdy = 1'b1;
    end
  endtask

  // Reference model: with every frame queued up front and each source
  // re-raising right after its ack, service alternates, starting with the
  // source not served last; each frame is A5, tag, length MSB/LSB, payload.
  task automatic build_expected();
    int len;
    bit pick_rsp;
    byte unsigned tag;
    while (mon_lens.size() > 0 || rsp_lens.size() > 0) begin
      if (mon_lens.size() == 0) pick_rsp = 1'b1;
      else if (rsp_lens.size() == 0) pick_rsp = 1'b0;
      else pick_rsp = !model_last_rsp;
      if (pick_rsp) begin
        len = rsp_lens.pop_front(); tag = 8'h02;
      end else begin
        len = mon_lens.pop_front(); tag = {7'b0, mon_srcs.pop_front()};
      end
      exp_bytes.push_back(8'hA5); exp_bytes.push_back(tag);
      exp_bytes.push_back(8'(len >> 8)); exp_bytes.push_back(8'(len % 256));
      for (int i = 0; i < len; i++)
        exp_bytes.push_back(pick_rsp ? rsp_data.pop_front() : mon_data.pop_front());
      exp_ack.push_back(pick_rsp ? 1 : 0);
      model_last_rsp = pick_rsp;
    end
  endtask

  // One clock: drive inputs after the falling edge, then sample what the DUT
  // will present at the next rising edge.
  task automatic step();
    @(negedge clk_ftdi);
    cyc++;
    bus.ftdi_txe_n = bp ? 1'($urandom_range(0, 1)) : 1'b0;
    if (mon_pend) begin
      if (mon_fifo.size() > 0) bus.mon_q = mon_fifo.pop_front(); else underflow++;
      mon_pend = 1'b0;
    end
    if (rsp_pend) begin
      if (rsp_fifo.size() > 0) bus.rsp_q = rsp_fifo.pop_front(); else underflow++;
      rsp_pend = 1'b0;
    end
    #1;
    if (bus.ftdi_wr_n === 1'b0) begin
      host.push_back(bus.ftdi_d); acc_cyc.push_back(cyc); last_acc_cyc = cyc;
    end
    if (bus.mon_rdreq === 1'b1 && bus.rsp_rdreq === 1'b1) excl_err++;
    if ((bus.mon_rdreq === 1'b1 || bus.rsp_rdreq === 1'b1) && bus.busy !== 1'b1) excl_err++;
    if (bus.mon_rdreq === 1'b1) begin mon_pend = 1'b1; mon_rd_cnt++; end
    if (bus.rsp_rdreq === 1'b1) begin rsp_pend = 1'b1; rsp_rd_cnt++; end
    if (bus.mon_rd_rdy_ack === 1'b1 || bus.rsp_rd_rdy_ack === 1'b1) begin
      if (cyc != last_acc_cyc + 1) timing_err++;
      if (cyc == prev_ack_cyc + 1) timing_err++;
      prev_ack_cyc = cyc;
    end
    if (bus.mon_rd_rdy_ack === 1'b1) begin
      ack_log.push_back(0); bus.mon_rd_rdy = 1'b0; raise_mon();
    end
    if (bus.rsp_rd_rdy_ack === 1'b1) begin
      ack_log.push_back(1); bus.rsp_rdy = 1'b0; raise_rsp();
    end
  endtask

  task automatic run_until(int n_acks, int budget, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ack_log.size() >= n_acks) begin timeout = 1'b0; break; end
    end
    repeat (4) step();
  endtask

  function automatic int stream_bad();
    int n;
    n = (host.size() < exp_bytes.size()) ? host.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) if (host[i] != exp_bytes[i]) return i;
    if (host.size() != exp_bytes.size()) return n;
    return -1;
  endfunction

  function automatic bit ack_bad();
    if (ack_log.size() != exp_ack.size()) return 1'b1;
    for (int i = 0; i < ack_log.size(); i++) if (ack_log[i] != exp_ack[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    clear_env();
    #12;
    checks++;
    if (bus.ftdi_wr_n !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_wr_n got=%b exp=1", bus.ftdi_wr_n);
    end
    checks++;
    if (bus.ftdi_d !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_ftdi_d got=%h exp=00", bus.ftdi_d);
    end
    checks++;
    if ({bus.mon_rdreq, bus.rsp_rdreq, bus.mon_rd_rdy_ack, bus.rsp_rd_rdy_ack, bus.busy} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=00000",
               {bus.mon_rdreq, bus.rsp_rdreq, bus.mon_rd_rdy_ack, bus.rsp_rd_rdy_ack, bus.busy});
    end
    @(negedge clk_ftdi);
    n_rst = 1'b1;
    model_last_rsp = 1'b1;
  endtask

  task automatic test_monitor_only();
    bit to;
    int start, bad, lat, hspan, p1, p2;
    clear_env(); step();
    add_mon(3, 1'b1, 1'b1);
    build_expected();
    start = cyc;
    raise_mon();
    run_until(1, 200, to);
    bad = stream_bad();
    checks++;
    if (to) begin failures++; $display("[TB] FAIL mon_timeout got=%0d acks exp=1", ack_log.size()); end
    checks++;
    if (bad != -1) begin
      failures++;
      $display("[TB] FAIL mon_stream idx=%0d got_len=%0d exp_len=%0d", bad, host.size(), exp_bytes.size());
    end
    checks++;
    if (ack_bad()) begin failures++; $display("[TB] FAIL mon_ack got=%0d acks exp=1 mon ack", ack_log.size()); end
    lat = -1; hspan = -1; p1 = -1; p2 = -1;
    if (acc_cyc.size() >= 7) begin
      lat = acc_cyc[0] - start; hspan = acc_cyc[3] - acc_cyc[0];
      p1 = acc_cyc[5] - acc_cyc[4]; p2 = acc_cyc[6] - acc_cyc[5];
    end
    checks++;
    if (lat != 1) begin failures++; $display("[TB] FAIL grant_latency got=%0d exp=1", lat); end
    checks++;
    if (hspan != 3) begin failures++; $display("[TB] FAIL header_rate got=%0d exp=3", hspan); end
    checks++;
    if (p1 != 2 || p2 != 2) begin failures++; $display("[TB] FAIL payload_rate got=%0d,%0d exp=2,2", p1, p2); end
    checks++;
    if (timing_err != 0) begin failures++; $display("[TB] FAIL mon_ack_timing got=%0d exp=0", timing_err); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL mon_busy_end got=%b exp=0", bus.busy); end
  endtask

  task automatic test_tie();
    bit to;
    int bad;
    clear_env(); do_reset(); step();
    add_mon(4, 1'b0, 1'b0); add_mon(2, 1'b1, 1'b0);
    add_rsp(2); add_rsp(1);
    build_expected();
    raise_mon(); raise_rsp();
    run_until(4, 400, to);
    bad = stream_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("[TB] FAIL tie_stream timeout=%0d idx=%0d got_len=%0d exp_len=%0d", to, bad, host.size(), exp_bytes.size());
    end
    checks++;
    if (ack_bad()) begin failures++; $display("[TB] FAIL tie_ack_order got=%0d acks exp=4", ack_log.size()); end
    checks++;
    if (ack_log.size() < 2 || ack_log[1] != 1) begin
      failures++; $display("[TB] FAIL tie_second_rsp got_acks=%0d exp second ack=rsp", ack_log.size());
    end
    checks++;
    if (excl_err != 0 || timing_err != 0 || underflow != 0) begin
      failures++; $display("[TB] FAIL tie_protocol got=%0d/%0d/%0d exp=0/0/0", excl_err, timing_err, underflow);
    end
  endtask

  task automatic test_zero_length();
    bit to;
    int bad;
    clear_env(); step();
    add_rsp(0);
    build_expected();
    raise_rsp();
    run_until(1, 100, to);
    bad = stream_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("[TB] FAIL zero_stream timeout=%0d idx=%0d got_len=%0d exp_len=4", to, bad, host.size());
    end
    checks++;
    if (ack_bad()) begin failures++; $display("[TB] FAIL zero_ack got=%0d acks exp=1 rsp ack", ack_log.size()); end
    checks++;
    if (rsp_rd_cnt != 0) begin failures++; $display("[TB] FAIL zero_rdreq got=%0d exp=0", rsp_rd_cnt); end
    checks++;
    if (timing_err != 0) begin failures++; $display("[TB] FAIL zero_ack_timing got=%0d exp=0", timing_err); end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad;
    clear_env(); step();
    bp = 1'b1;
    add_mon(300, 1'($urandom_range(0, 1)), 1'b0);
    build_expected();
    raise_mon();
    run_until(1, 5000, to);
    bad = stream_bad();
    checks++;
    if (to) begin failures++; $display("[TB] FAIL bp_timeout got=%0d acks exp=1", ack_log.size()); end
    checks++;
    if (bad != -1) begin
      failures++;
      $display("[TB] FAIL bp_stream idx=%0d got_len=%0d exp_len=%0d", bad, host.size(), exp_bytes.size());
    end
    checks++;
    if (host.size() < 4 || host[2] != 8'h01 || host[3] != 8'h2C) begin
      failures++; $display("[TB] FAIL bp_len_field got_len=%0d exp=012C", host.size());
    end
    checks++;
    if (ack_bad()) begin failures++; $display("[TB] FAIL bp_ack got=%0d acks exp=1", ack_log.size()); end
    checks++;
    if (timing_err != 0 || underflow != 0 || mon_rd_cnt != 300) begin
      failures++;
      $display("[TB] FAIL bp_protocol got=%0d/%0d/%0d exp=0/0/300", timing_err, underflow, mon_rd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int bad;
    for (int r = 0; r < 3; r++) begin
      clear_env(); step();
      bp = (r != 0);
      for (int f = 0; f < 3; f++) begin
        add_mon($urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'b0);
        add_rsp($urandom_range(0, 12));
      end
      build_expected();
      raise_mon(); raise_rsp();
      run_until(6, 2000, to);
      bad = stream_bad();
      checks++;
      if (to || bad != -1) begin
        failures++;
        $display("[TB] FAIL b2b_stream round=%0d timeout=%0d idx=%0d got_len=%0d exp_len=%0d",
                 r, to, bad, host.size(), exp_bytes.size());
      end
      checks++;
      if (ack_bad()) begin failures++; $display("[TB] FAIL b2b_ack_order round=%0d got=%0d acks exp=6", r, ack_log.size()); end
      checks++;
      if (excl_err != 0 || timing_err != 0 || underflow != 0) begin
        failures++;
        $display("[TB] FAIL b2b_protocol round=%0d got=%0d/%0d/%0d exp=0/0/0", r, excl_err, timing_err, underflow);
      end
    end
  endtask

  task automatic test_reset_mid_payload();
    bit to;
    int bad;
    byte unsigned saved[$];
    clear_env(); step();
    add_mon(10, 1'b0, 1'b0);
    saved = mon_fifo;
    build_expected();
    raise_mon();
    for (int i = 0; i < 200 && host.size() < 9; i++) step();
    n_rst = 1'b0;
    #1;
    checks++;
    if (bus.ftdi_wr_n !== 1'b1 || bus.ftdi_d !== 8'h00 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_outputs got=wr_n:%b d:%h busy:%b exp=1/00/0", bus.ftdi_wr_n, bus.ftdi_d, bus.busy);
    end
    checks++;
    if ({bus.mon_rdreq, bus.rsp_rdreq, bus.mon_rd_rdy_ack, bus.rsp_rd_rdy_ack} !== 4'b0) begin
      failures++;
      $display("[TB] FAIL abort_ctrl got=%b exp=0000",
               {bus.mon_rdreq, bus.rsp_rdreq, bus.mon_rd_rdy_ack, bus.rsp_rd_rdy_ack});
    end
    checks++;
    if (ack_log.size() != 0 || host.size() != 9) begin
      failures++; $display("[TB] FAIL abort_progress got acks=%0d bytes=%0d exp=0/9", ack_log.size(), host.size());
    end
    mon_fifo = saved;
    mon_pend = 1'b0; rsp_pend = 1'b0;
    host.delete(); acc_cyc.delete();
    @(negedge clk_ftdi);
    n_rst = 1'b1;
    run_until(1, 200, to);
    bad = stream_bad();
    checks++;
    if (to || bad != -1) begin
      failures++;
      $display("[TB] FAIL restart_stream timeout=%0d idx=%0d got_len=%0d exp_len=%0d", to, bad, host.size(), exp_bytes.size());
    end
    checks++;
    if (ack_bad()) begin failures++; $display("[TB] FAIL restart_ack got=%0d acks exp=1", ack_log.size()); end
  endtask

  initial begin
    test_reset();
    test_monitor_only();
    test_tie();
    test_zero_length();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_payload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_sched.md
# ftdi_tx_sched

Transmit scheduler for the FTDI synchronous-FIFO link in the `clk_ftdi` domain. It shares the single FT245 write port between two frame sources:

- the HSI monitor buffer, which holds captured master/slave frames followed by status bytes;
- a command-response buffer.

Each granted frame is sent as a 4-byte header followed by its payload. The block hands the frame-ready handshake back to its source once the last byte has been accepted by the FTDI chip.

## Interface

- `HDR_BYTE`, 8'hA5: first byte of every host frame
- `RSP_TAG`, 8'h02: tag byte for response frames; monitor frames use the tag {7'b0, `mon_src`}
- `clk_ftdi`  in  1  FTDI 60 MHz clock; the block's only clock
- `n_rst`  in  1  asynchronous active-low reset
- `mon_rd_rdy`  in  1  level: a complete monitor frame is buffered; held until acknowledged
- `mon_rd_rdy_ack`  out  1  one-cycle pulse: monitor frame fully sent
- `mon_src`  in  1  source of the last monitor frame (0 = master, 1 = slave)
- `mon_usedw`  in  11  monitor FIFO fill level
- `mon_rdreq`  out  1  monitor FIFO read strobe; `mon_q` is valid the following cycle
- `mon_q`  in  8  monitor FIFO data
- `rsp_rdy`  in  1  level: a response frame is ready; held until acknowledged
- `rsp_len`  in  11  response payload length, stable while `rsp_rdy` is high
- `rsp_rd_rdy_ack`  out  1  one-cycle pulse: response frame sent
- `rsp_rdreq`  out  1  response FIFO read strobe; `rsp_q` is valid the following cycle
- `rsp_q`  in  8  response FIFO data
- `ftdi_txe_n`  in  1  FTDI TX space available (active low)
- `ftdi_wr_n`  out  1  FTDI write strobe (active low)
- `ftdi_d`  out  8  FTDI data bus
- `busy`  out  1  high in every state except IDLE

## Operation

- **States:** IDLE, HDR, TAG, LEN_H, LEN_L, PAYLOAD, ACK.
- **Output register:** an 8-bit data register `ob` with a valid flag `ob_vld`.
  - `ftdi_wr_n = ~(ob_vld & ~ftdi_txe_n)`, combinational.
  - `ftdi_d = ob`.
  - A byte is accepted on any edge where `ftdi_wr_n` = 0. Acceptance clears `ob_vld` unless `ob` is reloaded on the same edge.
- **Arbitration (IDLE):** round-robin using a `last` flag.
  - Only one requester pending: grant it.
  - Both pending: grant the source not served last.
  - `last` resets to RSP, so the monitor wins the first tie.
- **On grant:** latch the source and the length.
  - Length is `mon_usedw` for the monitor, `rsp_len` for responses.
  - Monitor bytes written after the grant belong to the next frame.
- **Header states:** HDR, TAG, LEN_H and LEN_L each load one byte into `ob` and advance when that byte is accepted.
  - Bytes, in order: `HDR_BYTE`, then the tag, then {5'b0, len[10:8]}, then len[7:0].
- **PAYLOAD:**
  - Issue the granted source's `rdreq` when the remaining count is > 0, no read is in flight, and `ob` is empty or being accepted this cycle.
  - Load `q` into `ob` on the next cycle and decrement the 11-bit remaining counter.
  - Leave PAYLOAD when the counter is 0 and the final byte is accepted.
  - Length 0: LEN_L goes directly to ACK once its byte is accepted.
- **ACK:** pulse the granted source's ack for one cycle, update `last`, return to IDLE.
  - IDLE re-evaluates requests on the cycle after the ack, when the source has already dropped its ready level.
- **Flow control:** while `ftdi_txe_n` is high, `ob` holds its value and no `rdreq` is issued that would overrun `ob`. The FSM stalls in place with no byte lost or duplicated.
- **Exclusivity:** `mon_rdreq` and `rsp_rdreq` are never high together, and are never high outside PAYLOAD.

## Timing

- **Reset values:** state = IDLE, `ob_vld` = 0, `ftdi_wr_n` = 1, `ftdi_d` = 0, all `rdreq` and ack outputs = 0, `busy` = 0.
- **Reset during a transfer:** abort immediately; no ack is issued and the source keeps its ready level.
- **Grant latency:** ready seen in IDLE → HDR byte valid on `ftdi_d` the next cycle.
- **Header rate:** one byte per clock with `ftdi_txe_n` held low.
- **Payload rate:** one byte per 2 clocks with `ftdi_txe_n` held low (single read in flight).
- **Ack timing:** the ack pulse occurs exactly 1 cycle after the edge on which the last byte is accepted.
- **TXE rising on the same edge a byte is offered:** that byte is not accepted and is re-offered unchanged.

## Structure

- Shared package: the FSM state encoding, the default `HDR_BYTE` and `RSP_TAG` values, and the 11-bit length width.
- One natural sub-module: `ftdi_out_reg`, holding `ob`/`ob_vld` and generating the `ftdi_wr_n` accept logic.

## Test plan

- **Monitor-only frame:** `mon_rd_rdy`, `mon_src` = 1, `mon_usedw` = 3 (data 11 22 33), TXE low → bytes A5 01 00 03 11 22 33, then one `mon_rd_rdy_ack` pulse.
- **Tie:** both requesters pending from reset, response `rsp_len` = 2 → monitor frame is sent fully first, then the response with tag 02; a second simultaneous pending serves RSP first.
- **Zero length:** `rsp_len` = 0 → A5 02 00 00, ack, and `rsp_rdreq` never asserted.
- **Backpressure:** `ftdi_txe_n` toggled pseudo-randomly during a 300-byte payload → host sees exactly 300 payload bytes in order, 012C in the length field, and no duplicates.
- **Reset mid-payload:** `n_rst` asserted after 5 bytes → all outputs at reset values; after release, the frame restarts from A5 with no ack issued for the aborted attempt.
